// File: rtl/target_game_ctrl.sv
// Multi-channel reaction-game controller: N_CH targets cycle OFF/LIT on timers,
// synchronised active-low buttons score hits, timeouts count as misses.
// Optional feature: define PENALTY_EN to make presses on dark targets cost one point each.
module target_game_ctrl #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned ON_CYCLES   = 50000000,
  parameter int unsigned OFF_CYCLES  = 250000000,
  parameter int unsigned STAGGER     = 1000,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned N_LED       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [N_CH-1:0]    btn_n_i,
  output logic [N_CH-1:0]    target_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] misses_o,
  output logic [N_LED-1:0]   led_o,
  output logic               hit_pulse_o,
  output logic               miss_pulse_o
);

  // Sums need headroom for score plus up to N_CH increments before clamping.
  localparam int unsigned SUM_W = SCORE_W + $clog2(N_CH + 1) + 1;
  localparam logic [SUM_W-1:0] ScoreMax = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  typedef enum logic {StOff, StLit} ch_state_e;

  logic [N_CH-1:0]    sync_q [SYNC_STAGES];
  logic [N_CH-1:0]    prev_q;
  logic [N_CH-1:0]    btn_s;
  logic [N_CH-1:0]    press;
  ch_state_e          state_q [N_CH];
  ch_state_e          state_d [N_CH];
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0]    hit;
  logic [N_CH-1:0]    miss;
  logic [SUM_W-1:0]   n_hit, n_miss, score_sum, miss_sum;
  logic [SCORE_W-1:0] score_q, score_d, misses_q, misses_d, led_idx;
  logic [N_LED-1:0]   led_q, led_d;
  logic               hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
`ifdef PENALTY_EN
  logic [N_CH-1:0]    pen;
  logic [SUM_W-1:0]   n_pen;
`endif

  assign btn_s = sync_q[SYNC_STAGES-1];
  assign press = prev_q & ~btn_s;

  // Button synchroniser and edge detector; runs regardless of enable so no stale edge on resume.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= btn_n_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= btn_s;
    end
  end

  // Channel state and timer registers; reset staggers the OFF timers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= CNT_W'(i * STAGGER);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-channel next state; a press on the final LIT cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit     = '0;
    miss    = '0;
`ifdef PENALTY_EN
    pen     = '0;
`endif
    if (enable_i) begin
      for (int i = 0; i < N_CH; i++) begin
        unique case (state_q[i])
          StOff: begin
`ifdef PENALTY_EN
            pen[i] = press[i];
`endif
            if (cnt_q[i] == CNT_W'(OFF_CYCLES - 1)) begin
              state_d[i] = StLit;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          StLit: begin
            if (press[i]) begin
              state_d[i] = StOff;
              cnt_d[i]   = '0;
              hit[i]     = 1'b1;
            end else if (cnt_q[i] == CNT_W'(ON_CYCLES - 1)) begin
              state_d[i] = StOff;
              cnt_d[i]   = '0;
              miss[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // Lamp outputs follow the registered channel state.
  always_comb begin
    target_o = '0;
    for (int i = 0; i < N_CH; i++) target_o[i] = (state_q[i] == StLit);
  end

  // Saturating score/miss arithmetic and one-hot LED selection.
  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_hit  = n_hit + SUM_W'(hit[i]);
      n_miss = n_miss + SUM_W'(miss[i]);
    end
    score_sum = SUM_W'(score_q) + n_hit;
`ifdef PENALTY_EN
    n_pen = '0;
    for (int i = 0; i < N_CH; i++) n_pen = n_pen + SUM_W'(pen[i]);
    score_sum = (score_sum > n_pen) ? score_sum - n_pen : '0;
`endif
    score_d      = (score_sum > ScoreMax) ? '1 : score_sum[SCORE_W-1:0];
    miss_sum     = SUM_W'(misses_q) + n_miss;
    misses_d     = (miss_sum > ScoreMax) ? '1 : miss_sum[SCORE_W-1:0];
    hit_pulse_d  = |hit;
    miss_pulse_d = |miss;
    led_idx      = score_q % SCORE_W'(N_LED);
    led_d        = N_LED'(1) << led_idx;
  end

  // Score, miss, pulse and LED registers; LED trails score by one edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      score_q      <= '0;
      misses_q     <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      led_q        <= N_LED'(1);
    end else begin
      score_q      <= score_d;
      misses_q     <= misses_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      led_q        <= led_d;
    end
  end

  assign score_o      = score_q;
  assign misses_o     = misses_q;
  assign led_o        = led_q;
  assign hit_pulse_o  = hit_pulse_q;
  assign miss_pulse_o = miss_pulse_q;

endmodule

// File: tb/tb_target_game_ctrl.sv
// Self-checking bench for target_game_ctrl with a deadline-based reference model.
module tb_target_game_ctrl;

  localparam int N_CH = 4;
  localparam int ON   = 8;
  localparam int OFF  = 20;
  localparam int STG  = 3;
  localparam int SYNC = 2;
  localparam int SMAX = 15;
  localparam int NL   = 6;
`ifdef PENALTY_EN
  localparam bit PenEn = 1'b1;
`else
  localparam bit PenEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] btn_n;
  logic [3:0] target_o;
  logic [3:0] score_o, misses_o;
  logic [5:0] led_o;
  logic       hit_pulse_o, miss_pulse_o;

  int checks, errors;

  // Reference model state: absolute enabled-cycle time and per-channel deadlines.
  int         m_t;
  logic [3:0] m_lit;
  int         m_due [N_CH];
  int         m_score, m_misses;
  logic [3:0] hist [SYNC+1];
  logic       e_hit, e_miss;
  int         e_led;

  int first3, first0, npulse, hpulse, rem, saved, cnt, w, n;
  logic [3:0] rb, b;

  target_game_ctrl #(
    .N_CH(4), .ON_CYCLES(8), .OFF_CYCLES(20), .STAGGER(3), .CNT_W(5),
    .SCORE_W(4), .N_LED(6), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .btn_n_i(btn_n),
    .target_o(target_o), .score_o(score_o), .misses_o(misses_o), .led_o(led_o),
    .hit_pulse_o(hit_pulse_o), .miss_pulse_o(miss_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_lit = '0;
    for (int i = 0; i < N_CH; i++) m_due[i] = OFF - i * STG;
    m_score = 0;
    m_misses = 0;
    for (int k = 0; k <= SYNC; k++) hist[k] = '1;
    e_hit = 1'b0;
    e_miss = 1'b0;
    e_led = 0;
  endtask

  // One clock edge of the game, from the rules: press = released two samples ago, low now.
  task automatic model_step(input logic [3:0] bv, input logic en);
    logic [3:0] press;
    int nh, nm, np, s;
    press = hist[SYNC] & ~hist[SYNC-1];
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bv;
    e_led = m_score % NL;
    nh = 0; nm = 0; np = 0;
    if (en) begin
      m_t++;
      for (int i = 0; i < N_CH; i++) begin
        if (m_lit[i]) begin
          if (press[i]) begin
            nh++; m_lit[i] = 1'b0; m_due[i] = m_t + OFF;
          end else if (m_t == m_due[i]) begin
            nm++; m_lit[i] = 1'b0; m_due[i] = m_t + OFF;
          end
        end else begin
          if (press[i]) np++;
          if (m_t == m_due[i]) begin
            m_lit[i] = 1'b1; m_due[i] = m_t + ON;
          end
        end
      end
    end
    s = m_score + nh - (PenEn ? np : 0);
    if (s < 0) s = 0;
    if (s > SMAX) s = SMAX;
    m_score = s;
    m_misses = (m_misses + nm > SMAX) ? SMAX : m_misses + nm;
    e_hit = (nh > 0);
    e_miss = (nm > 0);
  endtask

  task automatic check_all();
    logic [5:0] el;
    el = 6'(1) << e_led;
    check("target", 32'(target_o), 32'(m_lit));
    check("score", 32'(score_o), 32'(m_score));
    check("misses", 32'(misses_o), 32'(m_misses));
    check("led", 32'(led_o), 32'(el));
    check("hit_pulse", 32'(hit_pulse_o), 32'(e_hit));
    check("miss_pulse", 32'(miss_pulse_o), 32'(e_miss));
  endtask

  task automatic tick(input logic [3:0] bv, input logic en);
    btn_n = bv;
    enable = en;
    @(posedge clk);
    model_step(bv, en);
    #1;
    check_all();
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_target", 32'(target_o), 32'd0);
    check("rst_score", 32'(score_o), 32'd0);
    check("rst_misses", 32'(misses_o), 32'd0);
    check("rst_led", 32'(led_o), 32'd1);
    check("rst_hit", 32'(hit_pulse_o), 32'd0);
    check("rst_miss", 32'(miss_pulse_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    btn_n = '1;
    model_reset();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; enable = 1'b0; btn_n = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Free-running targets with no presses: staggered rise, 8-cycle lit window, one miss each.
    first3 = -1; first0 = -1; npulse = 0;
    for (n = 1; n <= 40; n++) begin
      tick(4'hF, 1'b1);
      if (first3 < 0 && target_o[3]) first3 = n;
      if (first0 < 0 && target_o[0]) first0 = n;
      if (miss_pulse_o) npulse++;
    end
    check("rise3", 32'(first3), 32'd11);
    check("rise0", 32'(first0), 32'd20);
    check("miss_total", 32'(misses_o), 32'd4);
    check("miss_pulses", 32'(npulse), 32'd4);

    // Dual press landing on ch2's final lit edge, then a long hold on ch0.
    do_reset();
    hpulse = 0;
    for (n = 1; n <= 80; n++) begin
      b = 4'hF;
      if (n >= 20 && n <= 25) b[2:1] = 2'b00;
      if (n >= 24 && n <= 73) b[0] = 1'b0;
      tick(b, 1'b1);
      if (n == 21) check("ch2_last_lit", 32'(target_o[2]), 32'd1);
      if (n == 22) begin
        check("dual_score", 32'(score_o), 32'd2);
        check("dual_pulse", 32'(hit_pulse_o), 32'd1);
        check("dual_misses", 32'(misses_o), 32'd1);
        check("dual_targets", 32'(target_o[2:1]), 32'd0);
      end
      if (n == 25) check("ch0_lit", 32'(target_o[0]), 32'd1);
      if (n == 26) begin
        check("ch0_fall", 32'(target_o[0]), 32'd0);
        check("ch0_score", 32'(score_o), 32'd3);
      end
      if (n == 27) check("ch0_led", 32'(led_o), 32'b001000);
      if (n >= 27 && n <= 73 && hit_pulse_o) hpulse++;
    end
    check("hold_no_rehit", 32'(hpulse), 32'd0);

    // Reactive player drives the score into saturation.
    for (n = 0; n < 300; n++) tick(~m_lit, 1'b1);
    check("sat_score", 32'(score_o), 32'd15);
    check("sat_led", 32'(led_o), 32'b001000);
    w = 0;
    while (m_lit == '0 && w < 60) begin tick(4'hF, 1'b1); w++; end
    check("lit_before_reset", 32'(target_o != '0), 32'd1);
    do_reset();

    // Freeze mid-LIT with a button pulse during the freeze.
    w = 0;
    while (!m_lit[0] && w < 60) begin tick(4'hF, 1'b1); w++; end
    check("freeze_lit", 32'(target_o[0]), 32'd1);
    tick(4'hF, 1'b1);
    tick(4'hF, 1'b1);
    rem = m_due[0] - m_t;
    saved = m_score;
    for (n = 0; n < 30; n++) tick((n >= 3 && n <= 5) ? 4'hE : 4'hF, 1'b0);
    check("freeze_target", 32'(target_o[0]), 32'd1);
    check("freeze_score", 32'(score_o), 32'(saved));
    cnt = 0;
    while (target_o[0] && cnt < 50) begin tick(4'hF, 1'b1); cnt++; end
    check("resume_rem", 32'(cnt), 32'(rem));

    // Presses on a dark target: penalty build floors at 0, default build ignores them.
    do_reset();
    w = 0;
    while (m_score < 2 && w < 200) begin tick({3'b111, ~m_lit[0]}, 1'b1); w++; end
    check("pen_start", 32'(score_o), 32'd2);
    tick(4'hF, 1'b1);
    tick(4'hF, 1'b1);
    for (n = 0; n < 3; n++) begin
      tick(4'hE, 1'b1); tick(4'hE, 1'b1);
      tick(4'hF, 1'b1); tick(4'hF, 1'b1);
    end
    tick(4'hF, 1'b1);
    check("pen_final", 32'(score_o), PenEn ? 32'd0 : 32'd2);

    // Randomised play with occasional freezes.
    rb = 4'hF;
    for (n = 0; n < 800; n++) begin
      for (int i = 0; i < N_CH; i++) if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
      tick(rb, ($urandom_range(0, 7) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/target_game_ctrl.md
Name: target_game_ctrl

Overview:
- Parametrised multi-channel reaction-game controller; the next generation of the single-target hit/score block.
- N_CH independent target channels, each cycling OFF/LIT on programmable timers with staggered start.
- Synchronised, edge-detected active-low buttons.
- Saturating hit and miss counters, plus a one-hot score-modulo LED display.
- Sits between board push-buttons/target lamps and the top-level display logic.

Parameters:
N_CH, 4, number of target/button channels
ON_CYCLES, 50000000, clocks a target stays lit before counting as a miss
OFF_CYCLES, 250000000, clocks a target stays dark before relighting
STAGGER, 1000, per-channel reset offset of the OFF counter; require STAGGER*(N_CH-1) < OFF_CYCLES
CNT_W, 28, timer width; must hold max(ON_CYCLES, OFF_CYCLES)
SCORE_W, 8, width of score and misses
N_LED, 6, number of score LEDs
SYNC_STAGES, 2, button synchroniser depth (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = game running; 0 = freeze
btn_n  input  N_CH  asynchronous buttons, active low (pressed = 0)
target  output  N_CH  target lamps, 1 = lit
score  output  SCORE_W  hits, saturating
misses  output  SCORE_W  timed-out targets, saturating
led  output  N_LED  one-hot, led[score % N_LED]
hit_pulse  output  1  one-cycle strobe, one or more hits this cycle
miss_pulse  output  1  one-cycle strobe, one or more timeouts this cycle

Behaviour:
Interface: one clock, clk. Reset is asynchronous and active-high (reset).

Reset values:
- target=0, score=0, misses=0, led=1 (led[0] set).
- hit_pulse=0, miss_pulse=0.
- Synchroniser and edge-detect flops = 1 (released).
- Channel i: state OFF, cnt_i = i*STAGGER.
- Reset asserted mid-game aborts immediately; no pending hit is counted.

Input conditioning:
- btn_n[i] passes through SYNC_STAGES flops to give s_i, then one prev_i flop.
- press_i = prev_i & ~s_i (falling edge only).
- Holding a button produces exactly one press.
- Edge flops update even when enable=0, so no false edge on resume.

Per-channel FSM (advances only when enable=1):
- OFF: cnt++ each cycle. At cnt==OFF_CYCLES-1: go LIT, cnt<=0, target_i<=1.
- LIT: cnt++ each cycle.
  - press_i: go OFF, cnt<=0, target_i<=0, hit.
  - else at cnt==ON_CYCLES-1: go OFF, cnt<=0, target_i<=0, miss.
- Hit and timeout in the same cycle: hit wins, no miss.
- OFF with press_i: ignored (see optional feature).

Latency:
- target_i falls on the clock edge that registers press_i, i.e. SYNC_STAGES+1 rising edges after btn_n[i] is first sampled low.
- score updates on that same edge; led updates one edge later.

Counting rules:
- Per cycle: score += popcount(hits); misses += popcount(misses_this_cycle).
- Both saturate at 2^SCORE_W-1; never wrap.
- Wider intermediate sums; clamp before register.
- hit_pulse and miss_pulse are registered and coincide with the corresponding count update.

Freeze:
- With enable=0, FSMs, counters, score and misses hold.
- Pulses are 0; led keeps tracking score.

Optional Feature:
PENALTY_EN
- Defined: press_i while channel i is OFF decrements score by 1 per such channel per cycle, floored at 0. hit_pulse is not asserted.
- Hits and penalties in the same cycle: score <= clamp(score + hits - penalties, 0, max).
- Undefined: presses on dark targets are ignored; score is monotonic.

Test Plan:
Use N_CH=4, ON_CYCLES=8, OFF_CYCLES=20, STAGGER=3, SYNC_STAGES=2, SCORE_W=4, N_LED=6.
1. Reset release, enable=1, no presses: target[3] rises 11 cycles after release, target[0] at 20. Each stays lit 8 cycles, then misses increments by 1 and miss_pulse pulses once per channel.
2. Press btn_n[0] low for 50 cycles while target[0] is lit: target[0] falls 3 edges after first low sample; score 0->1, hit_pulse once, led 000001->000010. Holding the button gives no further hits.
3. Press btn_n[1] and btn_n[2] simultaneously while both are lit: score +2 in one cycle, single hit_pulse. Press on the final LIT cycle: hit counted, misses unchanged.
4. Drive 20 hits: score saturates at 15 and stays 15; led = bit 15%6=3. Assert reset mid-LIT: all outputs return to reset values asynchronously, before the next clk edge.
5. Toggle enable=0 for 30 cycles mid-LIT with btn_n pulsed low-high during freeze: no state change, no hit. After resume, the remaining LIT time is unchanged.
6. PENALTY_EN build, score=2, press an OFF channel: score=1; repeat three times: score floors at 0. Without PENALTY_EN: score unchanged.
